// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store memory master.
//   - lsu_state_t : access FSM states (IDLE, REQ, WAIT, DONE)
//   - lsu_size_t  : access size decoded from func3[1:0]
//   - F3_*        : RISC-V load/store func3 encodings
//   - size_decode / access_legal / byte_enables / store_lanes helpers
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Size depends only on the low two func3 bits; bit 2 is the unsigned flag.
    function automatic lsu_size_t size_decode(input logic [2:0] f3);
        lsu_size_t sz;
        case (f3[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Legal = known func3 for the direction and naturally aligned address.
    function automatic logic access_legal(input logic       is_load,
                                          input logic [2:0] f3,
                                          input logic [1:0] offset);
        logic f3_ok;
        logic aligned;
        if (is_load) begin
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end else begin
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        case (size_decode(f3))
            SZ_HALF: aligned = ~offset[0];
            SZ_WORD: aligned = (offset == 2'b00);
            default: aligned = 1'b1;
        endcase
        return f3_ok & aligned;
    endfunction

    function automatic logic [3:0] byte_enables(input lsu_size_t  sz,
                                                input logic [1:0] offset);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << offset;
            SZ_HALF: be = 4'b0011 << {offset[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate narrow store data across all lanes so the byte enables
    // alone pick the target bytes.
    function automatic logic [31:0] store_lanes(input lsu_size_t   sz,
                                                input logic [31:0] d);
        logic [31:0] lanes;
        case (sz)
            SZ_BYTE: lanes = {4{d[7:0]}};
            SZ_HALF: lanes = {2{d[15:0]}};
            default: lanes = d;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load-data extraction.
// Ports:
//   rdata  in  32  raw read word from the bus
//   offset in  2   byte offset within the word (addr[1:0])
//   func3  in  3   access size / sign encoding
//   unsign in  1   force zero-extension
//   data   out 32  selected and extended load result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    input  logic        unsign,
    output logic [31:0] data
);

    logic       zext;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        zext = unsign | func3[2];
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size_decode(func3))
            SZ_BYTE: data = {{24{~zext & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{~zext & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: drives a req/gnt/rvalid data-memory bus on behalf of the
// single-cycle core, stalling it until each load/store completes.
// Optional build macro: LSU_TIMEOUT_EN adds a watchdog that abandons an
// access after TIMEOUT_CYCLES cycles in REQ/WAIT (access_err pulse,
// load_data cleared).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rd_en, wr_en, unsign, func3 decoded load/store controls
//   addr, wdata                 ALU byte address, rs2 store data
//   stall                       hold PC/regfile while access in flight
//   load_data                   extended load result (valid in DONE)
//   access_err                  one-cycle pulse: illegal/misaligned/timeout
//   mem_req/we/addr/be/wdata    bus request side
//   mem_gnt, mem_rvalid, mem_rdata  bus response side
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic              unsign,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              access_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("lsu_mem_master: TIMEOUT_CYCLES must be at least 1");
    end

    lsu_state_t        state_reg;
    lsu_state_t        state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [2:0]        func3_reg;
    logic              unsign_reg;
    logic              op_read_reg;
    logic [3:0]        be_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       load_data_reg;

    logic              req_any;
    logic              legal;
    logic              start;
    logic              timeout_hit;
    logic              load_clear;
    logic [31:0]       aligned_data;

    assign req_any = rd_en | wr_en;
    // rd_en wins when both are asserted, so legality is checked as a load.
    assign legal   = access_legal(rd_en, func3, addr[1:0]);
    assign start   = (state_reg == S_IDLE) && req_any && legal;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] count_reg;

    // Cleared while idle so every access starts from zero on IDLE->REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (state_reg == S_IDLE) begin
            count_reg <= '0;
        end else if ((state_reg == S_REQ) || (state_reg == S_WAIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Fires in the last allowed cycle, so the access spends exactly
    // TIMEOUT_CYCLES cycles in REQ/WAIT before DONE.
    assign timeout_hit = ((state_reg == S_REQ) || (state_reg == S_WAIT)) &&
                         (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        access_err = 1'b0;
        load_clear = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req_any && legal) begin
                    state_next = S_REQ;
                    stall      = 1'b1;
                end else if (req_any) begin
                    access_err = 1'b1;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (mem_gnt) begin
                    state_next = op_read_reg ? S_WAIT : S_DONE;
                end else if (timeout_hit) begin
                    state_next = S_DONE;
                    access_err = 1'b1;
                    load_clear = 1'b1;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    state_next = S_DONE;
                end else if (timeout_hit) begin
                    state_next = S_DONE;
                    access_err = 1'b1;
                    load_clear = 1'b1;
                end
            end
            default: begin
                // DONE: the core commits this cycle; inputs now belong to
                // the next instruction and are only looked at from IDLE.
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg      <= '0;
            func3_reg     <= 3'b000;
            unsign_reg    <= 1'b0;
            op_read_reg   <= 1'b0;
            be_reg        <= 4'b0000;
            wdata_reg     <= 32'h0;
            load_data_reg <= 32'h0;
        end else begin
            if (start) begin
                addr_reg    <= addr;
                func3_reg   <= func3;
                unsign_reg  <= unsign;
                op_read_reg <= rd_en;
                be_reg      <= byte_enables(size_decode(func3), addr[1:0]);
                wdata_reg   <= store_lanes(size_decode(func3), wdata);
            end
            if ((state_reg == S_WAIT) && mem_rvalid) begin
                load_data_reg <= aligned_data;
            end else if (load_clear) begin
                load_data_reg <= 32'h0;
            end
        end
    end

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .offset (addr_reg[1:0]),
        .func3  (func3_reg),
        .unsign (unsign_reg),
        .data   (aligned_data)
    );

    // Request-side outputs come straight from registers, so they stay stable
    // for the whole REQ phase and fall to zero the moment reset asserts.
    assign mem_req   = (state_reg == S_REQ);
    assign mem_we    = mem_req & ~op_read_reg;
    assign mem_be    = mem_req ? be_reg : 4'b0000;
    assign mem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
    assign mem_wdata = wdata_reg;
    assign load_data = load_data_reg;

endmodule
